// File: rtl/axi_lite_master_bridge.sv
// Bridges a CPU/cache request port to AXI4: INCR reads of 1-16 beats, single-beat strobed writes, one outstanding.
// Performance counters are compiled in when the macro AXI_MASTER_PERF_EN is defined.
module axi_lite_master_bridge #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ID_W   = 4,
  parameter int unsigned MST_ID = 0
) (
  input  logic                ACLK,
  input  logic                ARESETn,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [3:0]          req_len,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_wstrb,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_last,
  output logic                rsp_err,
  output logic [ID_W-1:0]     AWID,
  output logic [ADDR_W-1:0]   AWADDR,
  output logic [3:0]          AWLEN,
  output logic [2:0]          AWSIZE,
  output logic [1:0]          AWBURST,
  output logic                AWVALID,
  input  logic                AWREADY,
  output logic [DATA_W-1:0]   WDATA,
  output logic [DATA_W/8-1:0] WSTRB,
  output logic                WLAST,
  output logic                WVALID,
  input  logic                WREADY,
  input  logic [ID_W-1:0]     BID,
  input  logic [1:0]          BRESP,
  input  logic                BVALID,
  output logic                BREADY,
  output logic [ID_W-1:0]     ARID,
  output logic [ADDR_W-1:0]   ARADDR,
  output logic [3:0]          ARLEN,
  output logic [2:0]          ARSIZE,
  output logic [1:0]          ARBURST,
  output logic                ARVALID,
  input  logic                ARREADY,
  input  logic [ID_W-1:0]     RID,
  input  logic [DATA_W-1:0]   RDATA,
  input  logic [1:0]          RRESP,
  input  logic                RLAST,
  input  logic                RVALID,
  output logic                RREADY
`ifdef AXI_MASTER_PERF_EN
  ,
  output logic [31:0]         perf_rd_cnt,
  output logic [31:0]         perf_wr_cnt,
  output logic [31:0]         perf_stall_cnt
`endif
);

  localparam int unsigned STRB_W = DATA_W / 8;
  localparam logic [ID_W-1:0] MST_ID_V = ID_W'(MST_ID);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_RADDR = 3'd1,
    S_RDATA = 3'd2,
    S_WREQ  = 3'd3,
    S_WRESP = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q;
  logic [3:0]          len_q;
  logic [3:0]          cnt_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [STRB_W-1:0]   wstrb_q;
  logic [ID_W-1:0]     id_q;
  logic                aw_done_q;
  logic                w_done_q;
  logic                beat_last;
  logic                unused_addr_lsb;

  assign beat_last       = (cnt_q == len_q);
  assign unused_addr_lsb = ^req_addr[1:0];

  // State register
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (req_valid) state_d = req_write ? S_WREQ : S_RADDR;
      S_RADDR: if (ARREADY) state_d = S_RDATA;
      S_RDATA: if (RVALID && rsp_ready && beat_last) state_d = S_IDLE;
      S_WREQ:  if ((aw_done_q || AWREADY) && (w_done_q || WREADY)) state_d = S_WRESP;
      S_WRESP: if (BVALID && rsp_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Handshake outputs and response pass-through; the early-RLAST case is flagged but the count governs
  always_comb begin
    req_ready = 1'b0;
    ARVALID   = 1'b0;
    RREADY    = 1'b0;
    AWVALID   = 1'b0;
    WVALID    = 1'b0;
    BREADY    = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = '0;
    rsp_last  = 1'b0;
    rsp_err   = 1'b0;
    case (state_q)
      S_IDLE:  req_ready = 1'b1;
      S_RADDR: ARVALID = 1'b1;
      S_RDATA: begin
        RREADY    = rsp_ready;
        rsp_valid = RVALID;
        rsp_rdata = RDATA;
        rsp_last  = beat_last;
        rsp_err   = (RRESP != 2'b00) | (RLAST != beat_last) | (RID != MST_ID_V);
      end
      S_WREQ: begin
        AWVALID = !aw_done_q;
        WVALID  = !w_done_q;
      end
      S_WRESP: begin
        BREADY    = rsp_ready;
        rsp_valid = BVALID;
        rsp_last  = 1'b1;
        rsp_err   = (BRESP != 2'b00) | (BID != MST_ID_V);
      end
      default: ;
    endcase
  end

  // Request capture, beat counter and per-channel write completion flags
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      addr_q    <= '0;
      len_q     <= '0;
      cnt_q     <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      id_q      <= '0;
      aw_done_q <= 1'b0;
      w_done_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: if (req_valid) begin
          addr_q    <= {req_addr[ADDR_W-1:2], 2'b00};
          len_q     <= req_len;
          wdata_q   <= req_wdata;
          wstrb_q   <= req_wstrb;
          id_q      <= MST_ID_V;
          aw_done_q <= 1'b0;
          w_done_q  <= 1'b0;
        end
        S_RADDR: if (ARREADY) cnt_q <= '0;
        S_RDATA: if (RVALID && rsp_ready) cnt_q <= cnt_q + 4'd1;
        S_WREQ: begin
          if (AWVALID && AWREADY) aw_done_q <= 1'b1;
          if (WVALID && WREADY)   w_done_q  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign AWID    = id_q;
  assign AWADDR  = addr_q;
  assign AWLEN   = 4'd0;
  assign AWSIZE  = 3'b010;
  assign AWBURST = 2'b01;
  assign WDATA   = wdata_q;
  assign WSTRB   = wstrb_q;
  assign WLAST   = 1'b1;
  assign ARID    = id_q;
  assign ARADDR  = addr_q;
  assign ARLEN   = len_q;
  assign ARSIZE  = 3'b010;
  assign ARBURST = 2'b01;

`ifdef AXI_MASTER_PERF_EN
  logic stall;
  assign stall = (AWVALID & !AWREADY) | (WVALID & !WREADY) |
                 (ARVALID & !ARREADY) | (rsp_valid & !rsp_ready);

  // Free-running wrap-around event counters
  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      perf_rd_cnt    <= '0;
      perf_wr_cnt    <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (state_q == S_RDATA && RVALID && rsp_ready && beat_last) perf_rd_cnt <= perf_rd_cnt + 32'd1;
      if (state_q == S_WRESP && BVALID && rsp_ready)              perf_wr_cnt <= perf_wr_cnt + 32'd1;
      if (stall)                                                  perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
